// File: rtl/shift_add_multiplier_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier.
// The 4-bit ripple adder is an external instance: this block drives its
// operands and consumes its sum/carry-out once per iteration. Four iterations
// follow each accepted start, then a one-cycle done pulse is raised and the
// 8-bit product is held until the next completion.

module shift_add_multiplier_seq (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] i_a_in,
  input  logic [3:0] i_b_in,
  output logic [3:0] o_add_a,
  output logic [3:0] o_add_b,
  output logic       o_add_cin,
  input  logic [3:0] i_add_sum,
  input  logic       i_add_cout,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_product
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Adder operand B: the multiplicand when the current multiplier bit is set.
  function automatic logic [3:0] gate_operand(input logic [3:0] mcand,
                                              input logic       sel);
    gate_operand = sel ? mcand : 4'h0;
  endfunction

  state_t     r_state;
  logic [3:0] r_mcand;
  logic [3:0] r_acc_hi;
  logic [3:0] r_acc_lo;
  logic [1:0] r_cnt;
  logic [7:0] r_product;
  logic       r_busy;
  logic       r_done;

  logic [3:0] w_add_b;
  logic [7:0] w_shifted;

  // Adder operands and the shifted partial product; the adder carry becomes
  // the new top bit so no bit of the 5-bit partial sum is lost.
  always_comb begin
    w_add_b   = gate_operand(r_mcand, r_acc_lo[0]);
    w_shifted = {i_add_cout, i_add_sum, r_acc_lo[3:1]};
  end

  assign o_add_a   = r_acc_hi;
  assign o_add_b   = w_add_b;
  assign o_add_cin = 1'b0;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_product;

  // Control FSM with operand/accumulator datapath and registered status/result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_mcand   <= 4'h0;
      r_acc_hi  <= 4'h0;
      r_acc_lo  <= 4'h0;
      r_cnt     <= 2'd0;
      r_product <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_mcand  <= i_a_in;
            r_acc_lo <= i_b_in;
            r_acc_hi <= 4'h0;
            r_cnt    <= 2'd0;
            r_busy   <= 1'b1;
            r_state  <= ST_CALC;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        ST_CALC: begin
          // start and the operand inputs are deliberately ignored here.
          {r_acc_hi, r_acc_lo} <= w_shifted;
          r_cnt                <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_product <= w_shifted;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= ST_CALC;
          end
        end

        ST_DONE: begin
          r_done <= 1'b0;
          // A start seen during the done cycle begins the next multiply at once.
          if (i_start) begin
            r_mcand  <= i_a_in;
            r_acc_lo <= i_b_in;
            r_acc_hi <= 4'h0;
            r_cnt    <= 2'd0;
            r_busy   <= 1'b1;
            r_state  <= ST_CALC;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_cnt   <= 2'd0;
        end
      endcase
    end
  end

  shift_add_multiplier_seq_chk u_chk (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_busy (r_busy),
    .i_done (r_done)
  );

endmodule

// Protocol checks on the status outputs.
module shift_add_multiplier_seq_chk (
  input logic i_clk,
  input logic i_rst,
  input logic i_busy,
  input logic i_done
);

  // busy and done are never asserted together.
  a_busy_done_excl: assert property (
    @(posedge i_clk) disable iff (i_rst) !(i_busy && i_done)
  );

  // done is a single-cycle pulse.
  a_done_pulse: assert property (
    @(posedge i_clk) disable iff (i_rst) i_done |=> !i_done
  );

endmodule

// File: tb/tb_shift_add_multiplier_seq.sv
// Self-checking bench for shift_add_multiplier_seq: supplies a behavioural
// 4-bit adder, runs directed and random multiplies and checks status timing,
// adder operands and the product against arithmetic expectations.

module tb_shift_add_multiplier_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_sum;
  logic       add_cout;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_prod = 0;

  always #5 clk = ~clk;

  // External adder model.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

  shift_add_multiplier_seq dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_a_in     (a_in),
    .i_b_in     (b_in),
    .o_add_a    (add_a),
    .o_add_b    (add_b),
    .o_add_cin  (add_cin),
    .i_add_sum  (add_sum),
    .i_add_cout (add_cout),
    .o_busy     (busy),
    .o_done     (done),
    .o_product  (product)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge (the accepting edge).
  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
  endtask

  // Checks the four CALC cycles and the DONE cycle of a multiply already
  // accepted. Optionally pulses a spurious start mid-CALC, and optionally
  // chains a new start during the done cycle.
  task automatic mul_body(input logic [3:0] a, input logic [3:0] b,
                          input bit interfere, input bit chain,
                          input logic [3:0] na, input logic [3:0] nb);
    int ai = int'(a);
    int bi = int'(b);
    for (int k = 0; k < 4; k++) begin
      start = 1'b0;
      check_eq("calc_busy", int'(busy), 1);
      check_eq("calc_done", int'(done), 0);
      check_eq("calc_hold_product", int'(product), exp_prod);
      check_eq("calc_add_cin", int'(add_cin), 0);
      check_eq("calc_add_a", int'(add_a), (ai * (bi % (1 << k))) >> k);
      check_eq("calc_add_b", int'(add_b), ((bi >> k) & 1) != 0 ? ai : 0);
      if (interfere && k == 1) begin
        a_in  = 4'hF;
        b_in  = 4'hF;
        start = 1'b1;
      end else begin
        a_in = 4'($urandom_range(0, 15));
        b_in = 4'($urandom_range(0, 15));
      end
      tick();
    end
    exp_prod = ai * bi;
    check_eq("done_pulse", int'(done), 1);
    check_eq("done_busy", int'(busy), 0);
    check_eq("done_product", int'(product), exp_prod);
    if (chain) begin
      a_in  = na;
      b_in  = nb;
      start = 1'b1;
      tick();
    end else begin
      start = 1'b0;
      tick();
      check_eq("idle_done", int'(done), 0);
      check_eq("idle_busy", int'(busy), 0);
      check_eq("idle_product", int'(product), exp_prod);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ra, rb, na, nb;
    bit         ch;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = 4'h0;
    b_in  = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_done", int'(done), 0);
    check_eq("reset_product", int'(product), 0);

    // Largest operands: carry must survive into the top bit.
    issue(4'hF, 4'hF);
    mul_body(4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 4'h0);
    check_eq("ff_product", int'(product), 8'hE1);

    issue(4'h5, 4'h3);
    mul_body(4'h5, 4'h3, 1'b0, 1'b0, 4'h0, 4'h0);
    check_eq("5x3_product", int'(product), 8'h0F);

    issue(4'h0, 4'h9);
    mul_body(4'h0, 4'h9, 1'b0, 1'b0, 4'h0, 4'h0);
    issue(4'hA, 4'h1);
    mul_body(4'hA, 4'h1, 1'b0, 1'b0, 4'h0, 4'h0);

    // Spurious start and operand changes during CALC are ignored.
    issue(4'h3, 4'h7);
    mul_body(4'h3, 4'h7, 1'b1, 1'b0, 4'h0, 4'h0);
    check_eq("ignored_start_product", int'(product), 8'h15);

    // Reset in the second CALC cycle discards the partial result.
    issue(4'hC, 4'hD);
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_prod = 0;
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_done", int'(done), 0);
    check_eq("midrst_product", int'(product), 0);
    issue(4'hC, 4'hD);
    mul_body(4'hC, 4'hD, 1'b0, 1'b0, 4'h0, 4'h0);

    // Back-to-back: start held through the done cycle.
    issue(4'h2, 4'h3);
    mul_body(4'h2, 4'h3, 1'b0, 1'b1, 4'h4, 4'h4);
    mul_body(4'h4, 4'h4, 1'b0, 1'b0, 4'h0, 4'h0);
    check_eq("b2b_second_product", int'(product), 8'h10);

    // Random multiplies, some chained back-to-back.
    ra = 4'($urandom_range(0, 15));
    rb = 4'($urandom_range(0, 15));
    issue(ra, rb);
    for (int i = 0; i < 24; i++) begin
      ch = (i != 23) && ($urandom_range(0, 1) == 1);
      na = 4'($urandom_range(0, 15));
      nb = 4'($urandom_range(0, 15));
      mul_body(ra, rb, 1'b0, ch, na, nb);
      ra = na;
      rb = nb;
      if (!ch && i != 23) begin
        issue(ra, rb);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
